// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch FIFO and single-port RAM bus arbiter; data accesses beat prefetches.
// Optional PREFETCH_STATS_EN builds saturating fetch/discard counters.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        wire_clock,
  input  logic        wire_reset_n,
  output logic [15:0] bus_RAM_ADDRESS,
  output logic        wire_RW,
  output logic [15:0] bus_RAM_DATA_IN,
  input  logic [15:0] bus_RAM_DATA_OUT,
  output logic        instr_valid,
  output logic [15:0] instr_data,
  output logic [15:0] instr_addr,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        dreq,
  input  logic        dwe,
  input  logic [15:0] daddr,
  input  logic [15:0] dwdata,
  output logic [15:0] drdata,
  output logic        dack,
  output logic [3:0]  instr_count,
  output logic [15:0] stat_fetches,
  output logic [15:0] stat_discards
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic        epoch_q, epoch_d;

  logic [15:0] bus_addr_q, bus_addr_d;
  logic        bus_rw_q, bus_rw_d;
  logic [15:0] bus_wdata_q, bus_wdata_d;

  // Tag pipe: stage 1 is aligned with the bus registers, stage 2 with returning RAM data.
  logic        s1_valid_q, s1_data_q, s1_write_q, s1_epoch_q;
  logic [15:0] s1_addr_q;
  logic        s1_valid_d, s1_data_d, s1_write_d, s1_epoch_d;
  logic [15:0] s1_addr_d;
  logic        s2_valid_q, s2_data_q, s2_write_q, s2_epoch_q;
  logic [15:0] s2_addr_q;

  logic [15:0]     fifo_addr_q [DEPTH];
  logic [15:0]     fifo_data_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]      count_q, count_d;

  logic        dack_q, dack_d;
  logic [15:0] drdata_q, drdata_d;

  logic        data_busy, data_accept, fetch_issue;
  logic        s1_fetch, s2_fetch, push, pop, discard, head_valid;
  logic [3:0]  count_eff;
  logic [4:0]  credit_used;
  logic [15:0] issue_pc;

  assign s1_fetch   = s1_valid_q & ~s1_data_q;
  assign s2_fetch   = s2_valid_q & ~s2_data_q;
  assign head_valid = (count_q != 4'd0);

  // dack_q counts as busy because the requester still holds dreq on the edge ending dack.
  assign data_busy   = (s1_valid_q & s1_data_q) | (s2_valid_q & s2_data_q) | dack_q;
  assign data_accept = dreq & ~data_busy;

  // Stale in-flight fetches still hold credit; this is conservative but never overflows.
  assign count_eff   = redirect ? 4'd0 : count_q;
  assign credit_used = {1'b0, count_eff} + {4'd0, s1_fetch} + {4'd0, s2_fetch};
  assign fetch_issue = ~data_accept & (credit_used < 5'(DEPTH));
  assign issue_pc    = redirect ? redirect_pc : fetch_pc_q;

  assign push    = s2_fetch & (s2_epoch_q == epoch_q) & ~redirect;
  assign discard = s2_fetch & ~push;
  assign pop     = head_valid & instr_ready & ~redirect;

  always_comb begin
    fetch_pc_d = fetch_issue ? issue_pc + 16'd1 : issue_pc;
    epoch_d    = redirect ? ~epoch_q : epoch_q;

    bus_addr_d  = bus_addr_q;
    bus_rw_d    = 1'b0;
    bus_wdata_d = bus_wdata_q;
    if (data_accept) begin
      bus_addr_d  = daddr;
      bus_rw_d    = dwe;
      bus_wdata_d = dwdata;
    end else if (fetch_issue) begin
      bus_addr_d = issue_pc;
    end

    s1_valid_d = data_accept | fetch_issue;
    s1_data_d  = data_accept;
    s1_write_d = data_accept & dwe;
    s1_epoch_d = epoch_d;
    s1_addr_d  = data_accept ? daddr : issue_pc;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 4'd0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    dack_d   = s2_valid_q & s2_data_q;
    drdata_d = drdata_q;
    if (s2_valid_q & s2_data_q & ~s2_write_q) drdata_d = bus_RAM_DATA_OUT;
  end

  always_ff @(posedge wire_clock or negedge wire_reset_n) begin
    if (!wire_reset_n) begin
      fetch_pc_q  <= RESET_PC;
      epoch_q     <= 1'b0;
      bus_addr_q  <= 16'h0000;
      bus_rw_q    <= 1'b0;
      bus_wdata_q <= 16'h0000;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= 1'b0;
      s1_write_q  <= 1'b0;
      s1_epoch_q  <= 1'b0;
      s1_addr_q   <= 16'h0000;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= 1'b0;
      s2_write_q  <= 1'b0;
      s2_epoch_q  <= 1'b0;
      s2_addr_q   <= 16'h0000;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 4'd0;
      dack_q      <= 1'b0;
      drdata_q    <= 16'h0000;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      epoch_q     <= epoch_d;
      bus_addr_q  <= bus_addr_d;
      bus_rw_q    <= bus_rw_d;
      bus_wdata_q <= bus_wdata_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_write_q  <= s1_write_d;
      s1_epoch_q  <= s1_epoch_d;
      s1_addr_q   <= s1_addr_d;
      s2_valid_q  <= s1_valid_q;
      s2_data_q   <= s1_data_q;
      s2_write_q  <= s1_write_q;
      s2_epoch_q  <= s1_epoch_q;
      s2_addr_q   <= s1_addr_q;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dack_q      <= dack_d;
      drdata_q    <= drdata_d;
    end
  end

  // Storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge wire_clock) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= s2_addr_q;
      fifo_data_q[wr_ptr_q] <= bus_RAM_DATA_OUT;
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [15:0] stat_fetches_q, stat_discards_q;

  always_ff @(posedge wire_clock or negedge wire_reset_n) begin
    if (!wire_reset_n) begin
      stat_fetches_q  <= 16'h0000;
      stat_discards_q <= 16'h0000;
    end else begin
      if (fetch_issue && stat_fetches_q != 16'hFFFF) stat_fetches_q <= stat_fetches_q + 16'd1;
      if (discard && stat_discards_q != 16'hFFFF) stat_discards_q <= stat_discards_q + 16'd1;
    end
  end

  assign stat_fetches  = stat_fetches_q;
  assign stat_discards = stat_discards_q;
`else
  logic unused_discard;
  assign unused_discard = discard;
  assign stat_fetches   = 16'h0000;
  assign stat_discards  = 16'h0000;
`endif

  assign bus_RAM_ADDRESS = bus_addr_q;
  assign wire_RW         = bus_rw_q;
  assign bus_RAM_DATA_IN = bus_wdata_q;
  assign instr_valid     = head_valid;
  assign instr_addr      = head_valid ? fifo_addr_q[rd_ptr_q] : 16'h0000;
  assign instr_data      = head_valid ? fifo_data_q[rd_ptr_q] : 16'h0000;
  assign instr_count     = count_q;
  assign dack            = dack_q;
  assign drdata          = drdata_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a synchronous single-port RAM model.
module tb_instr_prefetch_queue;

  logic        wire_clock = 1'b0;
  logic        wire_reset_n;
  logic [15:0] bus_RAM_ADDRESS, bus_RAM_DATA_IN, bus_RAM_DATA_OUT;
  logic        wire_RW;
  logic        instr_valid, instr_ready;
  logic [15:0] instr_data, instr_addr;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        dreq, dwe, dack;
  logic [15:0] daddr, dwdata, drdata;
  logic [3:0]  instr_count;
  logic [15:0] stat_fetches, stat_discards;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [65536];

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .wire_clock      (wire_clock),
    .wire_reset_n    (wire_reset_n),
    .bus_RAM_ADDRESS (bus_RAM_ADDRESS),
    .wire_RW         (wire_RW),
    .bus_RAM_DATA_IN (bus_RAM_DATA_IN),
    .bus_RAM_DATA_OUT(bus_RAM_DATA_OUT),
    .instr_valid     (instr_valid),
    .instr_data      (instr_data),
    .instr_addr      (instr_addr),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .dreq            (dreq),
    .dwe             (dwe),
    .daddr           (daddr),
    .dwdata          (dwdata),
    .drdata          (drdata),
    .dack            (dack),
    .instr_count     (instr_count),
    .stat_fetches    (stat_fetches),
    .stat_discards   (stat_discards)
  );

  always #5 wire_clock = ~wire_clock;

  always @(posedge wire_clock) begin
    if (wire_RW) mem[bus_RAM_ADDRESS] <= bus_RAM_DATA_IN;
    bus_RAM_DATA_OUT <= mem[bus_RAM_ADDRESS];
  end

  task automatic tick();
    @(posedge wire_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addr"}, bus_RAM_ADDRESS, 16'h0000);
    check({tag, "_rw"}, {15'd0, wire_RW}, 16'h0000);
    check({tag, "_wdata"}, bus_RAM_DATA_IN, 16'h0000);
    check({tag, "_valid"}, {15'd0, instr_valid}, 16'h0000);
    check({tag, "_count"}, {12'd0, instr_count}, 16'h0000);
    check({tag, "_idata"}, instr_data, 16'h0000);
    check({tag, "_iaddr"}, instr_addr, 16'h0000);
    check({tag, "_dack"}, {15'd0, dack}, 16'h0000);
    check({tag, "_drdata"}, drdata, 16'h0000);
    check({tag, "_sfetch"}, stat_fetches, 16'h0000);
    check({tag, "_sdisc"}, stat_discards, 16'h0000);
  endtask

  initial begin
    logic [15:0] exp_disc;
`ifdef PREFETCH_STATS_EN
    exp_disc = 16'd2;
`else
    exp_disc = 16'd0;
`endif
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5A5;

    wire_reset_n = 1'b0;
    instr_ready  = 1'b1;
    redirect     = 1'b0;
    redirect_pc  = 16'h0000;
    dreq         = 1'b0;
    dwe          = 1'b0;
    daddr        = 16'h0000;
    dwdata       = 16'h0000;

    // Reset release, streaming fetches
    tick();
    check_reset("rst0");
    wire_reset_n = 1'b1;
    tick();
    check("e1_addr", bus_RAM_ADDRESS, 16'h0000);
    check("e1_valid", {15'd0, instr_valid}, 16'h0000);
    tick();
    check("e2_addr", bus_RAM_ADDRESS, 16'h0001);
    check("e2_valid", {15'd0, instr_valid}, 16'h0000);
    tick();
    check("e3_valid", {15'd0, instr_valid}, 16'h0001);
    check("e3_iaddr", instr_addr, 16'h0000);
    check("e3_idata", instr_data, 16'hA5A5);
    tick();
    check("e4_iaddr", instr_addr, 16'h0001);
    check("e4_idata", instr_data, 16'hA5A4);
    tick();
    check("e5_iaddr", instr_addr, 16'h0002);
    check("e5_idata", instr_data, 16'hA5A7);

    // Asynchronous reset clears outputs immediately, then fill with no consumer
    wire_reset_n = 1'b0;
    instr_ready  = 1'b0;
    #1;
    check_reset("rst1");
    tick();
    wire_reset_n = 1'b1;
    repeat (8) tick();
    check("full_count", {12'd0, instr_count}, 16'h0004);
    check("full_rw", {15'd0, wire_RW}, 16'h0000);
    check("full_addr", bus_RAM_ADDRESS, 16'h0003);
    check("full_head", instr_addr, 16'h0000);
    tick();
    check("full_hold_addr", bus_RAM_ADDRESS, 16'h0003);
    check("full_hold_count", {12'd0, instr_count}, 16'h0004);
    instr_ready = 1'b1;
    tick();
    check("drain1", instr_addr, 16'h0001);
    check("drain1_count", {12'd0, instr_count}, 16'h0003);
    tick();
    check("drain2", instr_addr, 16'h0002);
    check("resume_addr", bus_RAM_ADDRESS, 16'h0004);
    tick();
    check("drain3", instr_addr, 16'h0003);
    tick();
    check("drain4", instr_addr, 16'h0004);
    check("drain4_data", instr_data, 16'hA5A1);
    tick();

    // Redirect with two fetches in flight
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    check("rd_valid0", {15'd0, instr_valid}, 16'h0000);
    check("rd_count0", {12'd0, instr_count}, 16'h0000);
    check("rd_addr0", bus_RAM_ADDRESS, 16'h0100);
    tick();
    check("rd_valid1", {15'd0, instr_valid}, 16'h0000);
    tick();
    check("rd_valid2", {15'd0, instr_valid}, 16'h0001);
    check("rd_iaddr", instr_addr, 16'h0100);
    check("rd_idata", instr_data, 16'hA4A5);
    check("rd_discards", stat_discards, exp_disc);
    tick();
    check("rd_iaddr1", instr_addr, 16'h0101);

    // Store then load to 0200
    dreq   = 1'b1;
    dwe    = 1'b1;
    daddr  = 16'h0200;
    dwdata = 16'h1234;
    tick();
    check("st_addr", bus_RAM_ADDRESS, 16'h0200);
    check("st_rw", {15'd0, wire_RW}, 16'h0001);
    check("st_wdata", bus_RAM_DATA_IN, 16'h1234);
    check("st_dack0", {15'd0, dack}, 16'h0000);
    tick();
    check("st_rw1", {15'd0, wire_RW}, 16'h0000);
    check("st_dack1", {15'd0, dack}, 16'h0000);
    tick();
    check("st_dack2", {15'd0, dack}, 16'h0001);
    tick();
    check("st_dack3", {15'd0, dack}, 16'h0000);
    check("st_no_reaccept", {15'd0, wire_RW}, 16'h0000);
    dreq = 1'b0;
    dwe  = 1'b0;
    tick();
    dreq = 1'b1;
    tick();
    check("ld_addr", bus_RAM_ADDRESS, 16'h0200);
    check("ld_rw", {15'd0, wire_RW}, 16'h0000);
    tick();
    check("ld_dack1", {15'd0, dack}, 16'h0000);
    tick();
    check("ld_dack2", {15'd0, dack}, 16'h0001);
    check("ld_drdata", drdata, 16'h1234);
    tick();
    check("ld_dack3", {15'd0, dack}, 16'h0000);
    dreq = 1'b0;
    tick();

    // Redirect near the top of the address space
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    check("wrap0_addr", instr_addr, 16'hFFFE);
    check("wrap0_data", instr_data, 16'h5A5B);
    tick();
    check("wrap1_addr", instr_addr, 16'hFFFF);
    check("wrap1_data", instr_data, 16'h5A5A);
    tick();
    check("wrap2_addr", instr_addr, 16'h0000);
    check("wrap2_data", instr_data, 16'hA5A5);

    // Reset during an outstanding load
    dreq  = 1'b1;
    dwe   = 1'b0;
    daddr = 16'h0200;
    tick();
    check("rl_addr", bus_RAM_ADDRESS, 16'h0200);
    wire_reset_n = 1'b0;
    dreq         = 1'b0;
    #1;
    check_reset("rst2");
    tick();
    wire_reset_n = 1'b1;
    tick();
    check("rl_pc", bus_RAM_ADDRESS, 16'h0000);
    check("rl_dack1", {15'd0, dack}, 16'h0000);
    tick();
    check("rl_dack2", {15'd0, dack}, 16'h0000);
    tick();
    check("rl_dack3", {15'd0, dack}, 16'h0000);
    check("rl_valid", {15'd0, instr_valid}, 16'h0001);
    check("rl_iaddr", instr_addr, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Instruction prefetch and RAM bus arbiter between the single-port program/data RAM and the CPU core. Fetches sequential instruction words ahead of the core into a small FIFO, hands them out with a valid/ready handshake, and gives core data loads/stores (LOAD, STORE, LOADI, STOREI) priority on the shared RAM bus. A PC redirect (jump, call, return) flushes queued and in-flight fetches.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..8
- RESET_PC, 16'h0000, first fetch address after reset

- wire_clock  in  1  system clock, rising edge
- wire_reset_n  in  1  reset, asynchronous, active-low
- bus_RAM_ADDRESS  out  16  RAM address, registered
- wire_RW  out  1  RAM write strobe (1 = write, 0 = read), registered
- bus_RAM_DATA_IN  out  16  RAM write data, registered
- bus_RAM_DATA_OUT  in  16  RAM read data for the address driven in the previous cycle
- instr_valid  out  1  FIFO head valid
- instr_data  out  16  head instruction word
- instr_addr  out  16  head instruction address
- instr_ready  in  1  core pops head when instr_valid && instr_ready
- redirect  in  1  one-cycle PC redirect pulse
- redirect_pc  in  16  new fetch address
- dreq  in  1  data access request, held until dack
- dwe  in  1  1 = store, 0 = load
- daddr  in  16  data address
- dwdata  in  16  store data
- drdata  out  16  load data, valid with dack
- dack  out  1  one-cycle access completion
- instr_count  out  4  FIFO occupancy
- stat_fetches  out  16  fetch counter (see Configuration)
- stat_discards  out  16  discard counter (see Configuration)

## Operation
- One bus slot per clock edge. Priority: data access > prefetch > idle.
- Data accepted when dreq=1 and no data access outstanding: bus gets daddr, wire_RW=dwe, bus_RAM_DATA_IN=dwdata.
- Prefetch issued when no data accepted and instr_count + in-flight fetches < DEPTH: bus gets fetch_pc, wire_RW=0; fetch_pc <= fetch_pc+1 (16-bit wrap, FFFF->0000).
- Idle slot: wire_RW=0, address holds last value.
- Two-stage tag pipe tracks each slot: {valid, is_data, epoch, addr}. Stage 2 captures bus_RAM_DATA_OUT: fetch tag with current epoch pushes {addr, data} into FIFO; stale epoch is dropped (stat_discards++); data-read tag drives drdata; any data tag asserts dack.
- redirect: FIFO emptied, epoch toggled (all in-flight fetches stale), data tags unaffected. If a prefetch issues on the same edge it uses redirect_pc directly and fetch_pc <= redirect_pc+1; else fetch_pc <= redirect_pc.
- Redirect concurrent with pop: redirect wins; popped entry discarded with the rest.
- Push and pop same edge: count unchanged. Full FIFO never overflows (credit rule).
- Reset: all outputs 0, FIFO empty, tags invalid, epoch 0, fetch_pc=RESET_PC, counters 0.

## Timing
- Accept/issue decided at edge k; bus driven during cycle k..k+1; RAM samples at edge k+1 (writes commit here); read data captured at edge k+2.
- Fetch latency: issue at edge k -> instr_valid high after edge k+2.
- First instruction after reset release: instr_valid high after third rising edge.
- Data latency: dreq sampled at edge k -> dack high for one cycle after edge k+2. dreq ignored while outstanding; requester drops dreq at the edge ending the dack cycle.
- Sustained throughput: one fetch per cycle with instr_ready=1 and no data traffic.
- Reset asserted mid-transfer: outputs clear immediately, pending data access lost, no dack.

## Configuration
- PREFETCH_STATS_EN defined: stat_fetches counts issued prefetches, stat_discards counts stale-epoch drops; both 16-bit, saturate at FFFF, clear on reset.
- Undefined: counters not built, stat_fetches and stat_discards tied to 16'h0000.

## Test plan
- Reset release, RAM mem[i]=i^16'hA5A5, instr_ready=1 -> instr_valid after edge 3; instr_addr 0000,0001,0002; instr_data A5A5,A5A4,A5A7; one per cycle.
- instr_ready=0 -> instr_count settles at 4, then wire_RW=0 with no new addresses; release -> addresses 0000..0003 popped in order, prefetch resumes at 0004.
- redirect to 0100 with two fetches in flight -> both dropped (stat_discards=2 with macro), next instr_addr=0100, instr_valid two cycles after redirect.
- Store dreq, daddr=0200, dwdata=1234 then load daddr=0200 -> each dack two cycles after acceptance, drdata=1234; no prefetch issued on accept edges.
- redirect to FFFE -> instr_addr FFFE, FFFF, 0000.
- wire_reset_n low during an outstanding load -> all outputs 0 immediately, no dack after release, fetch restarts at RESET_PC.
